counter_cmd_arbiter: RTL and testbench

- Owns one shared up/down counter and arbitrates counter commands from NREQ requesters, for example host trigger-in bits, debounced buttons and other fabric logic.
- An internal clock-divider tick acts as an extra lowest-priority "autocount" requester.
- Produces the count value plus one-cycle event pulses sized to drive trigger-out endpoints directly.
- Sits between endpoint/trigger decode and the wire-out/trigger-out endpoints, all in one clock domain.

---
 rtl/counter_cmd_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter: one shared up/down counter fed by NREQ round-robin
// requesters plus a lowest-priority autocount requester driven by an internal
// clock divider. Emits one-cycle event pulses for trigger-out endpoints.
//
// Ports:
//   clk, reset      - block clock, synchronous active-high reset
//   enable          - 1 runs arbitration and divider, 0 freezes everything
//   autocount       - 1 lets divider ticks raise an internal up-request
//   wrap_en         - 1 wraps at the counter limits, 0 saturates
//   req_valid       - per-requester command valid
//   req_op          - per-requester op, requester i at [2i+1:2i]
//   req_ready       - one-hot grant (combinational from req_valid)
//   count           - registered counter value
//   grant_id        - last accepted requester, 7 = autocount
//   ev_zero/ev_max  - count changed into 0 / all-ones
//   ev_wrap         - an up/down op wrapped
//   ev_overrun      - an autocount tick was lost
module counter_cmd_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4194304
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 autocount,
    input  logic                 wrap_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic [WIDTH-1:0]     count,
    output logic [2:0]           grant_id,
    output logic                 ev_zero,
    output logic                 ev_max,
    output logic                 ev_wrap,
    output logic                 ev_overrun
);

    localparam int unsigned PW = 3;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]    DIV_RELOAD = DW'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [PW-1:0]    AUTO_ID    = PW'(7);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [DW-1:0]    div_q;
    logic [DW-1:0]    div_nxt;
    logic [PW-1:0]    rr_ptr_q;
    logic [PW-1:0]    rr_ptr_nxt;
    logic             auto_pend_q;
    logic             auto_pend_nxt;
    logic [PW-1:0]    grant_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             overrun_nxt;

    logic [7:0]       valid_pad;
    logic [15:0]      op_pad;
    logic [PW-1:0]    scan_idx;
    logic [PW-1:0]    winner;
    logic             found;
    logic             any_valid;
    logic             xfer;
    logic             tick;
    logic             auto_svc;
    logic [1:0]       win_op;
    logic [1:0]       op_sel;

    // Round-robin scan starting at rr_ptr; first valid index wins.
    always_comb begin
        valid_pad = 8'(req_valid);
        op_pad    = 16'(req_op);
        found     = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PW'((32'(rr_ptr_q) + k) % NREQ);
            if (!found && valid_pad[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Grant qualification; reset and enable=0 suppress any transfer.
    always_comb begin
        any_valid = |req_valid;
        xfer      = enable & ~reset & found;
        win_op    = op_pad[{winner, 1'b0} +: 2];
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = xfer && (winner == PW'(i));
        end
    end

    // Divider tick and autocount servicing (only when no external request).
    always_comb begin
        tick     = enable & (div_q == '0);
        auto_svc = enable & ~reset & autocount & auto_pend_q & ~any_valid;
        op_sel   = OP_NOP;
        if (xfer) begin
            op_sel = win_op;
        end else if (auto_svc) begin
            op_sel = OP_UP;
        end
    end

    // Divider next value: free-running down-counter with reload at zero.
    always_comb begin
        div_nxt = div_q;
        if (enable) begin
            div_nxt = (div_q == '0) ? DIV_RELOAD : div_q - DW'(1);
        end
    end

    // Pending autocount request; a tick landing on an unserviced pending
    // request is dropped and reported as an overrun.
    always_comb begin
        auto_pend_nxt = auto_pend_q;
        overrun_nxt   = 1'b0;
        if (enable) begin
            if (!autocount) begin
                auto_pend_nxt = 1'b0;
            end else if (tick) begin
                overrun_nxt   = auto_pend_q & ~auto_svc;
                auto_pend_nxt = 1'b1;
            end else if (auto_svc) begin
                auto_pend_nxt = 1'b0;
            end
        end
    end

    // Counter op application with wrap/saturate at the limits.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        case (op_sel)
            OP_UP: begin
                if (count == CNT_MAX) begin
                    if (wrap_en) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end
            OP_DOWN: begin
                if (count == '0) begin
                    if (wrap_en) begin
                        count_nxt = CNT_MAX;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
            OP_CLEAR: count_nxt = '0;
            default:  count_nxt = count;
        endcase
    end

    // Round-robin pointer and grant id bookkeeping.
    always_comb begin
        rr_ptr_nxt = rr_ptr_q;
        grant_nxt  = grant_id;
        if (xfer) begin
            rr_ptr_nxt = PW'((32'(winner) + 32'd1) % NREQ);
            grant_nxt  = winner;
        end else if (auto_svc) begin
            grant_nxt  = AUTO_ID;
        end
    end

    // State and registered outputs; events coincide with the new count.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= DIV_RELOAD;
            rr_ptr_q    <= '0;
            auto_pend_q <= 1'b0;
            count       <= '0;
            grant_id    <= '0;
            ev_zero     <= 1'b0;
            ev_max      <= 1'b0;
            ev_wrap     <= 1'b0;
            ev_overrun  <= 1'b0;
        end else begin
            div_q       <= div_nxt;
            rr_ptr_q    <= rr_ptr_nxt;
            auto_pend_q <= auto_pend_nxt;
            count       <= count_nxt;
            grant_id    <= grant_nxt;
            ev_zero     <= (count_nxt == '0) && (count != '0);
            ev_max      <= (count_nxt == CNT_MAX) && (count != CNT_MAX);
            ev_wrap     <= wrap_nxt;
            ev_overrun  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter (NREQ=4, WIDTH=8, DIV=4).
module tb_counter_cmd_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 4;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] UP  = 2'b01;
    localparam logic [1:0] DN  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             autocount;
    logic             wrap_en;
    logic [3:0]       req_valid;
    logic [7:0]       req_op;
    logic [3:0]       req_ready;
    logic [7:0]       count;
    logic [2:0]       grant_id;
    logic             ev_zero;
    logic             ev_max;
    logic             ev_wrap;
    logic             ev_overrun;
    logic [3:0]       evs;

    int tests;
    int fails;

    counter_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .autocount  (autocount),
        .wrap_en    (wrap_en),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .count      (count),
        .grant_id   (grant_id),
        .ev_zero    (ev_zero),
        .ev_max     (ev_max),
        .ev_wrap    (ev_wrap),
        .ev_overrun (ev_overrun)
    );

    assign evs = {ev_zero, ev_max, ev_wrap, ev_overrun};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        step();
        step();
        reset     = 1'b0;
    endtask

    task automatic issue(input int idx, input logic [1:0] op);
        req_valid = 4'(1 << idx);
        req_op    = 8'(op) << (2 * idx);
        step();
        req_valid = '0;
    endtask

    task automatic test_reset();
        enable    = 1'b1;
        autocount = 1'b0;
        wrap_en   = 1'b0;
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_op    = 8'h55;
        step();
        step();
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        tests++;
        if (count !== 8'h00) begin
            fails++;
            $display("FAIL reset_count: got %h expected 00", count);
        end
        tests++;
        if (grant_id !== 3'd0) begin
            fails++;
            $display("FAIL reset_grant: got %0d expected 0", grant_id);
        end
        tests++;
        if (evs !== 4'b0000) begin
            fails++;
            $display("FAIL reset_events: got %b expected 0000", evs);
        end
        reset     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_up();
        do_reset();
        req_valid = 4'b0001;
        req_op    = 8'h01;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            tests++;
            if (count !== 8'(i) || grant_id !== 3'd0 || evs !== 4'b0000) begin
                fails++;
                $display("FAIL single_up[%0d]: got count=%h grant=%0d ev=%b expected count=%h grant=0 ev=0000",
                         i, count, grant_id, evs, 8'(i));
            end
        end
        req_valid = '0;
    endtask

    task automatic test_rotate();
        do_reset();
        req_valid = 4'b1111;
        req_op    = 8'h55;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                fails++;
                $display("FAIL rotate_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
            end
            step();
            tests++;
            if (grant_id !== 3'(k % 4) || count !== 8'(k + 1)) begin
                fails++;
                $display("FAIL rotate_grant[%0d]: got grant=%0d count=%h expected grant=%0d count=%h",
                         k, grant_id, count, k % 4, 8'(k + 1));
            end
        end
        req_valid = '0;
    endtask

    task automatic test_wrap_sat();
        logic [1:0] ops  [12] = '{CLR, DN, DN, UP, UP, DN, DN, DN, UP, UP, UP, NOP};
        logic       wraps[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] cnts [12] = '{8'h00, 8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00,
                                  8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [3:0] evx  [12] = '{4'b0000, 4'b0110, 4'b0000, 4'b0100, 4'b1010, 4'b0000,
                                  4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            wrap_en = wraps[i];
            issue(2, ops[i]);
            tests++;
            if (count !== cnts[i] || evs !== evx[i] || grant_id !== 3'd2) begin
                fails++;
                $display("FAIL wrap_sat[%0d]: got count=%h ev=%b grant=%0d expected count=%h ev=%b grant=2",
                         i, count, evs, grant_id, cnts[i], evx[i]);
            end
        end
        wrap_en = 1'b0;
    endtask

    task automatic test_autocount();
        do_reset();
        autocount = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            tests++;
            if (count !== 8'((k < 5) ? 0 : (k - 1) / 4) ||
                grant_id !== 3'((k < 5) ? 0 : 7) || ev_overrun !== 1'b0) begin
                fails++;
                $display("FAIL autocount[%0d]: got count=%h grant=%0d ovr=%b expected count=%h grant=%0d ovr=0",
                         k, count, grant_id, ev_overrun, 8'((k < 5) ? 0 : (k - 1) / 4), (k < 5) ? 0 : 7);
            end
        end
        req_valid = 4'b0010;
        req_op    = 8'h04;
        for (int k = 13; k <= 17; k++) begin
            step();
            tests++;
            if (ev_overrun !== (k == 16) || grant_id !== 3'd1 || count !== 8'(k - 10)) begin
                fails++;
                $display("FAIL starve[%0d]: got ovr=%b grant=%0d count=%h expected ovr=%b grant=1 count=%h",
                         k, ev_overrun, grant_id, count, (k == 16), 8'(k - 10));
            end
        end
        req_valid = '0;
        step();
        tests++;
        if (count !== 8'h08 || grant_id !== 3'd7) begin
            fails++;
            $display("FAIL auto_resume: got count=%h grant=%0d expected count=08 grant=7", count, grant_id);
        end
        autocount = 1'b0;
    endtask

    task automatic test_enable_freeze();
        logic [7:0] exp_cnt[4] = '{8'h01, 8'h01, 8'h01, 8'h02};
        logic [2:0] exp_gnt[4] = '{3'd2, 3'd2, 3'd2, 3'd7};
        do_reset();
        enable    = 1'b0;
        autocount = 1'b1;
        req_valid = 4'b0100;
        req_op    = 8'h10;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000 || count !== 8'h00) begin
                fails++;
                $display("FAIL freeze[%0d]: got ready=%b count=%h expected ready=0000 count=00",
                         k, req_ready, count);
            end
            step();
        end
        enable = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL unfreeze_ready: got %b expected 0100", req_ready);
        end
        step();
        tests++;
        if (count !== 8'h01 || grant_id !== 3'd2) begin
            fails++;
            $display("FAIL unfreeze_xfer: got count=%h grant=%0d expected count=01 grant=2", count, grant_id);
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if (count !== exp_cnt[k] || grant_id !== exp_gnt[k]) begin
                fails++;
                $display("FAIL div_resume[%0d]: got count=%h grant=%0d expected count=%h grant=%0d",
                         k, count, grant_id, exp_cnt[k], exp_gnt[k]);
            end
        end
        autocount = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) issue(1, UP);
        tests++;
        if (count !== 8'h05) begin
            fails++;
            $display("FAIL mid_setup: got count=%h expected 05", count);
        end
        reset     = 1'b1;
        req_valid = 4'b0001;
        req_op    = 8'h01;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL mid_ready: got %b expected 0000", req_ready);
        end
        step();
        tests++;
        if (count !== 8'h00 || evs !== 4'b0000 || grant_id !== 3'd0) begin
            fails++;
            $display("FAIL mid_reset: got count=%h ev=%b grant=%0d expected count=00 ev=0000 grant=0",
                     count, evs, grant_id);
        end
        reset     = 1'b0;
        req_valid = 4'b0011;
        req_op    = 8'h05;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL mid_rrptr: got ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        autocount = 1'b0;
        wrap_en   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        test_reset();
        test_single_up();
        test_rotate();
        test_wrap_sat();
        test_autocount();
        test_enable_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
